// File: rtl/inst_cache_pkg.sv
// rtl/inst_cache_pkg.sv - shared defaults and refill state encoding for the instruction cache
package inst_cache_pkg;

  localparam int IC_LINE_WORDS = 4;
  localparam int IC_NUM_LINES  = 16;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_REQ  = 2'd1,
    IC_FILL = 2'd2
  } ic_state_e;

endpackage

// File: rtl/inst_cache_if.sv
// rtl/inst_cache_if.sv - line refill request/grant/beat bus between cache and instruction memory
interface inst_cache_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rdata,
    input  mem_rvalid
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rdata,
    output mem_rvalid
  );

endinterface

// File: rtl/inst_cache_refill_fsm.sv
// rtl/inst_cache_refill_fsm.sv - miss latch, request/fill sequencing and deferred flush for one line refill
module inst_cache_refill_fsm
  import inst_cache_pkg::*;
#(
  parameter int LINE_WORDS = IC_LINE_WORDS,
  parameter int OFF_W      = 2,
  parameter int IDX_W      = 4,
  parameter int TAG_W      = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             miss,
  input  logic [TAG_W-1:0] pc_tag,
  input  logic [IDX_W-1:0] pc_index,
  input  logic             flush,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  output logic             idle,
  output logic             mem_req,
  output logic             wr_en,
  output logic [OFF_W-1:0] beat,
  output logic             line_done,
  output logic             line_discard,
  output logic [TAG_W-1:0] miss_tag,
  output logic [IDX_W-1:0] miss_index
);

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  ic_state_e        state_q, state_d;
  logic [OFF_W-1:0] beat_q, beat_d;
  logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0] miss_index_q, miss_index_d;
  logic             flush_pending_q, flush_pending_d;

  always_comb begin
    state_d         = state_q;
    beat_d          = beat_q;
    miss_tag_d      = miss_tag_q;
    miss_index_d    = miss_index_q;
    flush_pending_d = flush_pending_q;
    mem_req         = 1'b0;
    wr_en           = 1'b0;
    line_done       = 1'b0;
    line_discard    = 1'b0;
    case (state_q)
      IC_IDLE: begin
        flush_pending_d = 1'b0;
        if (miss) begin
          miss_tag_d   = pc_tag;
          miss_index_d = pc_index;
          state_d      = IC_REQ;
        end
      end
      IC_REQ: begin
        mem_req         = 1'b1;
        flush_pending_d = flush_pending_q | flush;
        if (mem_gnt) begin
          beat_d  = '0;
          state_d = IC_FILL;
        end
      end
      IC_FILL: begin
        flush_pending_d = flush_pending_q | flush;
        if (mem_rvalid) begin
          wr_en  = 1'b1;
          beat_d = beat_q + OFF_W'(1);
          if (beat_q == LAST_BEAT) begin
            // a flush seen on the final beat counts as pending too
            line_done       = 1'b1;
            line_discard    = flush_pending_q | flush;
            flush_pending_d = 1'b0;
            state_d         = IC_IDLE;
          end
        end
      end
      default: state_d = IC_IDLE;
    endcase
    if (rst) begin
      mem_req      = 1'b0;
      wr_en        = 1'b0;
      line_done    = 1'b0;
      line_discard = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IC_IDLE;
      beat_q          <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      beat_q          <= beat_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  always_ff @(posedge clk) begin
    miss_tag_q   <= miss_tag_d;
    miss_index_q <= miss_index_d;
  end

  assign idle       = (state_q == IC_IDLE);
  assign beat       = beat_q;
  assign miss_tag   = miss_tag_q;
  assign miss_index = miss_index_q;

endmodule

// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - direct-mapped read-only instruction cache with combinational hit path
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int LINE_WORDS = IC_LINE_WORDS,
  parameter int NUM_LINES  = IC_NUM_LINES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         F_im_r_en,
  input  logic [31:0]  pc,
  input  logic         flush,
  output logic [31:0]  inst,
  output logic         inst_cache_ready,
  inst_cache_if.master mem
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  logic [OFF_W-1:0] pc_off;
  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic             unused_pc_lsb;

  assign pc_off        = pc[OFF_W+1:2];
  assign pc_idx        = pc[OFF_W+IDX_W+1:OFF_W+2];
  assign pc_tag        = pc[31:OFF_W+IDX_W+2];
  assign unused_pc_lsb = ^pc[1:0];

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES][LINE_WORDS];
  logic [31:0]          data_d [NUM_LINES][LINE_WORDS];

  logic             fsm_idle, fsm_req, wr_en, line_done, line_discard, hit, miss;
  logic [OFF_W-1:0] beat;
  logic [TAG_W-1:0] miss_tag;
  logic [IDX_W-1:0] miss_index;

  // a flush in the lookup cycle forces a miss; the refill starts once valids are clear
  assign hit  = ~rst & F_im_r_en & fsm_idle & ~flush & valid_q[pc_idx] & (tag_q[pc_idx] == pc_tag);
  assign miss = ~rst & F_im_r_en & ~hit & ~flush;

  assign inst             = hit ? data_q[pc_idx][pc_off] : 32'h0;
  assign inst_cache_ready = ~rst & (~F_im_r_en | hit);

  inst_cache_refill_fsm #(
    .LINE_WORDS(LINE_WORDS),
    .OFF_W     (OFF_W),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_refill_fsm (
    .clk         (clk),
    .rst         (rst),
    .miss        (miss),
    .pc_tag      (pc_tag),
    .pc_index    (pc_idx),
    .flush       (flush),
    .mem_gnt     (mem.mem_gnt),
    .mem_rvalid  (mem.mem_rvalid),
    .idle        (fsm_idle),
    .mem_req     (fsm_req),
    .wr_en       (wr_en),
    .beat        (beat),
    .line_done   (line_done),
    .line_discard(line_discard),
    .miss_tag    (miss_tag),
    .miss_index  (miss_index)
  );

  assign mem.mem_req  = fsm_req;
  assign mem.mem_addr = {miss_tag, miss_index, {(OFF_W+2){1'b0}}};

  always_comb begin
    valid_d = valid_q;
    if ((flush && fsm_idle) || line_discard) begin
      valid_d = '0;
    end else if (line_done) begin
      valid_d[miss_index] = 1'b1;
    end
  end

  always_comb begin
    tag_d  = tag_q;
    data_d = data_q;
    if (wr_en) begin
      data_d[miss_index][beat] = mem.mem_rdata;
    end
    if (line_done) begin
      tag_d[miss_index] = miss_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // tag and data contents are only trusted through valid, so they carry no reset
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_inst_cache.sv
// tb/tb_inst_cache.sv - directed bench for inst_cache with a behavioural refill memory
module tb_inst_cache;

  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        rst, en, flush;
  logic [31:0] pc, inst;
  logic        ready;

  always #5 clk = ~clk;

  inst_cache_if mem_if ();

  inst_cache #(.LINE_WORDS(4), .NUM_LINES(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .F_im_r_en       (en),
    .pc              (pc),
    .flush           (flush),
    .inst            (inst),
    .inst_cache_ready(ready),
    .mem             (mem_if.master)
  );

  int          checks = 0;
  int          errors = 0;
  int          gnt_delay = 1;
  logic        stray = 1'b0;
  int          cur_beat = -1;
  logic [31:0] req_log[$];

  int          m_state = 0;
  int          m_wait = 0;
  int          m_k = 0;
  logic [31:0] m_addr = 32'h0;
  logic        prev_req = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic        en;
    logic        exp_ready;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h90 + (a >> 2);
  endfunction

  // memory: grant gnt_delay cycles after req is seen, then LW back-to-back beats
  initial begin
    mem_if.mem_gnt    = 1'b0;
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      mem_if.mem_gnt    = 1'b0;
      mem_if.mem_rvalid = 1'b0;
      mem_if.mem_rdata  = 32'h0;
      cur_beat          = -1;
      if (rst) begin
        m_state = 0;
      end else begin
        case (m_state)
          0: begin
            if (mem_if.mem_req) begin
              m_addr = mem_if.mem_addr;
              m_k    = 0;
              if (gnt_delay == 0) begin
                mem_if.mem_gnt = 1'b1;
                m_state        = 2;
              end else begin
                m_wait  = gnt_delay;
                m_state = 1;
              end
            end else if (stray) begin
              mem_if.mem_rvalid = 1'b1;
              mem_if.mem_rdata  = 32'hDEADBEEF;
            end
          end
          1: begin
            if (stray) begin
              mem_if.mem_rvalid = 1'b1;
              mem_if.mem_rdata  = 32'hBADC0DE0;
            end
            m_wait = m_wait - 1;
            if (m_wait == 0) begin
              mem_if.mem_gnt = 1'b1;
              m_state        = 2;
            end
          end
          default: begin
            mem_if.mem_rvalid = 1'b1;
            mem_if.mem_rdata  = mem_word(m_addr + 32'(m_k * 4));
            cur_beat          = m_k;
            m_k               = m_k + 1;
            if (m_k == LW) m_state = 0;
          end
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (mem_if.mem_req && !prev_req) req_log.push_back(mem_if.mem_addr);
      prev_req = mem_if.mem_req;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_log(input string name, input int idx, input logic [31:0] exp);
    if (idx < req_log.size()) chk(name, req_log[idx], exp);
    else chk(name, 32'hFFFFFFFF, exp);
  endtask

  task automatic wait_ready(input string name, output int stalls);
    stalls = 0;
    while (!ready && stalls < 100) begin
      stalls++;
      cyc();
      settle();
    end
    chk({name, "_ready"}, {31'b0, ready}, 32'd1);
  endtask

  task automatic fetch(input logic [31:0] a, output int stalls);
    cyc();
    pc = a;
    en = 1'b1;
    settle();
    wait_ready("fetch", stalls);
  endtask

  task automatic wait_beat(input int b);
    int n = 0;
    while (cur_beat != b && n < 100) begin
      n++;
      cyc();
      settle();
    end
    chk("wait_beat", cur_beat, b);
  endtask

  initial begin
    int st;
    vecs[0] = '{32'h44,   1'b1, 1'b1, 32'hA1};
    vecs[1] = '{32'h48,   1'b1, 1'b1, 32'hA2};
    vecs[2] = '{32'h4C,   1'b1, 1'b1, 32'hA3};
    vecs[3] = '{32'h42,   1'b1, 1'b1, 32'hA0};
    vecs[4] = '{32'h50,   1'b0, 1'b1, 32'h0};
    vecs[5] = '{32'h1234, 1'b0, 1'b1, 32'h0};
    vecs[6] = '{32'h40,   1'b0, 1'b1, 32'h0};

    rst = 1'b1; en = 1'b0; flush = 1'b0; pc = 32'h0;
    cyc(); settle();
    chk("rst_ready", ready, 0);
    chk("rst_mem_req", mem_if.mem_req, 0);
    chk("rst_inst", inst, 0);
    cyc(); en = 1'b1; pc = 32'h40; settle();
    chk("rst_fetch_ready", ready, 0);
    chk("rst_fetch_req", mem_if.mem_req, 0);
    cyc(); rst = 1'b0; en = 1'b0; pc = 32'h1234; settle();
    chk("nofetch_ready", ready, 1);
    chk("nofetch_req", mem_if.mem_req, 0);

    // cold miss
    req_log.delete();
    cyc(); pc = 32'h40; en = 1'b1; settle();
    chk("cold_miss_ready", ready, 0);
    cyc(); settle();
    chk("cold_req", mem_if.mem_req, 1);
    chk("cold_addr", mem_if.mem_addr, 32'h40);
    wait_ready("cold", st);
    chk("cold_penalty", 32'(1 + st), 32'd7);
    chk("cold_inst", inst, 32'hA0);

    for (int i = 0; i < 7; i++) begin
      cyc(); pc = vecs[i].pc; en = vecs[i].en; settle();
      chk($sformatf("vec%0d_ready", i), ready, vecs[i].exp_ready);
      chk($sformatf("vec%0d_inst", i), inst, vecs[i].exp_inst);
      chk($sformatf("vec%0d_req", i), mem_if.mem_req, 0);
    end

    // zero-wait memory gives the minimum miss penalty
    gnt_delay = 0;
    fetch(32'h200, st);
    chk("zw_penalty", st, 6);
    chk("zw_inst", inst, mem_word(32'h200));
    gnt_delay = 1;

    // conflict miss on index 4
    req_log.delete();
    fetch(32'h140, st);
    chk("conf_penalty", st, 7);
    chk("conf_inst", inst, 32'hE0);
    fetch(32'h40, st);
    chk("conf_back_penalty", st, 7);
    chk("conf_back_inst", inst, 32'hA0);
    chk_log("conf_log0", 0, 32'h140);
    chk_log("conf_log1", 1, 32'h40);

    // pc change during fill
    req_log.delete();
    cyc(); pc = 32'h80; en = 1'b1; settle();
    chk("pcchg_miss", ready, 0);
    wait_beat(0);
    cyc(); pc = 32'hC0; settle();
    chk("pcchg_fill_ready", ready, 0);
    wait_ready("pcchg", st);
    chk("pcchg_inst", inst, 32'hC0);
    chk_log("pcchg_log0", 0, 32'h80);
    chk_log("pcchg_log1", 1, 32'hC0);
    fetch(32'h80, st);
    chk("pcchg_old_hit", st, 0);
    chk("pcchg_old_inst", inst, 32'hB0);

    // flush during beat 2 of the 0x40 refill
    fetch(32'h140, st);
    req_log.delete();
    cyc(); pc = 32'h40; settle();
    wait_beat(1);
    cyc(); flush = 1'b1; settle();
    cyc(); flush = 1'b0; settle();
    cyc(); settle();
    chk("flush_fill_lookup", ready, 0);
    wait_ready("flush_fill", st);
    chk("flush_fill_inst", inst, 32'hA0);
    chk_log("flush_log0", 0, 32'h40);
    chk_log("flush_log1", 1, 32'h40);
    fetch(32'h80, st);
    chk("flush_all_cleared", st, 7);

    // flush while idle and hitting
    cyc(); pc = 32'h40; settle();
    chk("pre_flush_hit", ready, 1);
    cyc(); flush = 1'b1; settle();
    chk("idle_flush_ready", ready, 0);
    chk("idle_flush_req", mem_if.mem_req, 0);
    cyc(); flush = 1'b0; settle();
    chk("post_flush_ready", ready, 0);
    chk("post_flush_req", mem_if.mem_req, 0);
    cyc(); settle();
    chk("post_flush_req2", mem_if.mem_req, 1);
    wait_ready("post_flush", st);
    chk("post_flush_inst", inst, 32'hA0);

    // reset during beat 1 of a refill, then stray beats
    cyc(); pc = 32'h140; settle();
    wait_beat(0);
    cyc(); rst = 1'b1; settle();
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_req", mem_if.mem_req, 0);
    chk("mid_rst_inst", inst, 0);
    cyc(); rst = 1'b0; stray = 1'b1; pc = 32'h40; settle();
    chk("post_rst_req", mem_if.mem_req, 0);
    chk("post_rst_ready", ready, 0);
    wait_ready("post_rst", st);
    stray = 1'b0;
    chk("post_rst_penalty", st, 7);
    chk("post_rst_inst", inst, 32'hA0);
    for (int i = 1; i < LW; i++) begin
      cyc(); pc = 32'h40 + 32'(4 * i); settle();
      chk($sformatf("post_rst_w%0d", i), inst, mem_word(32'h40 + 32'(4 * i)));
    end

    cyc(); en = 1'b0; pc = 32'h777; settle();
    chk("final_nofetch_ready", ready, 1);
    chk("final_nofetch_req", mem_if.mem_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
Direct-mapped, read-only instruction cache between the IF-stage PC and external instruction memory.
- Drives the pipeline controller's inst_cache_ready and supplies the fetched instruction word.
- Hits are returned combinationally in the same cycle.
- Misses are refilled one full line at a time over a simple request/grant/beat memory interface.
- A flush input invalidates all lines, for fence.i and program reload.

Parameters:
- LINE_WORDS, 4: 32-bit words per line; must be a power of two, at least 2.
- NUM_LINES, 16: number of lines; must be a power of two, at least 2.
- Derived: OFF_W = log2(LINE_WORDS); IDX_W = log2(NUM_LINES); TAG_W = 30 - OFF_W - IDX_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- F_im_r_en  in  1  IF-stage fetch request.
- pc  in  32  fetch byte address; bits [1:0] are ignored.
- flush  in  1  invalidate all lines.
- inst  out  32  instruction word; valid when inst_cache_ready=1 and F_im_r_en=1.
- inst_cache_ready  out  1  high when there is a hit or no fetch request.
- mem_req  out  1  line refill request, held until granted.
- mem_addr  out  32  line-aligned byte address of the refill; stable while mem_req=1.
- mem_gnt  in  1  memory accepted the request.
- mem_rdata  in  32  refill beat data.
- mem_rvalid  in  1  refill beat valid; beats arrive in ascending word order.

Behaviour:
- Address split: offset = pc[OFF_W+1:2]; index = pc[OFF_W+IDX_W+1:OFF_W+2]; tag = pc[31:OFF_W+IDX_W+2].
- Storage: valid[NUM_LINES], tag[NUM_LINES], and data[NUM_LINES][LINE_WORDS], all in flops.
- hit = F_im_r_en & state==IDLE & valid[index] & tag[index]==tag.
- inst = data[index][offset] when hit, otherwise 0.
- inst_cache_ready = ~F_im_r_en | hit. It is 0 in any non-IDLE state while F_im_r_en=1.
- FSM states (encodings in the package):
  - IDLE: on F_im_r_en & ~hit & ~flush, latch miss_tag and miss_index from pc and go to REQ.
  - REQ: mem_req=1 and mem_addr = {miss_tag, miss_index, OFF_W+2 zero bits}. When mem_gnt=1, clear the beat counter and go to FILL. mem_req drops in the cycle after the grant.
  - FILL: each mem_rvalid writes mem_rdata into data[miss_index][beat] and increments beat. On the last beat (beat == LINE_WORDS-1), write tag[miss_index]=miss_tag, set valid[miss_index]=1 unless a flush is pending, and go to IDLE.
- After a refill, the next IDLE cycle re-evaluates the current pc; the refilled line then hits.
- Minimum miss penalty is 1 REQ cycle + LINE_WORDS beats + 1 lookup cycle, i.e. 6 cycles at defaults with zero-wait memory.
- A pc change during REQ or FILL does not abort the refill. The latched line completes, then the new pc is looked up.
- mem_rvalid in IDLE or REQ is ignored. mem_gnt outside REQ is ignored.
- Flush:
  - In IDLE: all valid bits clear at the next edge. A fetch in the same cycle is treated as a miss and the FSM does not leave IDLE; the miss is taken in the next cycle.
  - In REQ or FILL: set flush_pending. The refill completes normally but its valid bit is not set. flush_pending clears on return to IDLE, and all valids are cleared then.
- Reset, including mid-refill: state=IDLE, valid all 0, beat=0, flush_pending=0, mem_req=0. Data and tag arrays are not reset. While rst=1: inst_cache_ready=0, inst=0, mem_req=0. The memory side shares rst, so an aborted refill is discarded.
- Memory must not issue more than LINE_WORDS beats per grant.

Decomposition:
- Add IC_IDLE=2'd0, IC_REQ=2'd1, IC_FILL=2'd2 to rv32_define.v.
- One sub-module, inst_cache_refill_fsm: holds the state, beat counter, miss latches and flush_pending, and outputs the write strobe, beat index and line-done.
- The tag/valid/data arrays and the hit logic stay in inst_cache.

Test Plan (defaults; memory grants 1 cycle after req, then 4 back-to-back beats):
- Cold miss: reset, then F_im_r_en=1, pc=0x40.
  - ready=0; mem_req=1 with mem_addr=0x40.
  - After beats 0xA0..0xA3 and one more cycle: ready=1, inst=0xA0.
  - pc=0x44/0x48/0x4C then hit with inst 0xA1/0xA2/0xA3, each with ready=1 in the same cycle.
- Conflict miss: with pc=0x40 resident, fetch pc=0x140 (same index 4, tag 1).
  - Expect a refill at 0x140; afterwards pc=0x40 misses again and requests 0x40.
- PC change mid-fill: miss on 0x80, then switch pc to 0xC0 during FILL.
  - The fill of 0x80 completes, then a second request for 0xC0 is issued.
  - 0x80 hits afterwards.
- Flush mid-fill: assert flush for 1 cycle during beat 2 of the refill of 0x40.
  - The refill completes, valid[4]=0, and pc=0x40 misses again.
- Reset mid-fill: assert rst during beat 1.
  - Next cycle: mem_req=0 and FSM in IDLE.
  - pc=0x40 misses, and stray mem_rvalid beats are ignored.
- No fetch: F_im_r_en=0 with any pc → ready=1 and no mem_req, including right after reset.
